token_decoder: RTL and testbench

Reverse of the vocabulary matcher. It takes a token index and locates the corresponding null-terminated word in the vocab SRAM, then streams that word's bytes out over a valid/ready interface. The vocab image is words packed back-to-back, each terminated by 0x00; word k begins at the address after the k-th 0x00. The block sits behind the matcher in the tokenizer path as the detokenizer, and it drives a read-only port of the shared vocab sram.

---
 rtl/tokenizer_pkg.sv | 8 +
 rtl/token_decoder_if.sv | 27 ++
 rtl/token_decoder_vocab_reader.sv | 25 ++
 rtl/token_decoder.sv | 94 +++++++++
 tb/tb_token_decoder.sv | 129 ++++++++++++
 5 files changed

// File: rtl/tokenizer_pkg.sv
// tokenizer_pkg: shared FSM states and vocab-image constants for the tokenizer path.
package tokenizer_pkg;
  typedef enum logic [2:0] {IDLE, SKIP, EMIT, OUT, DONE} state_t;
  localparam int NULL_CHAR = 0;
  function automatic int end_addr(input int aw);
    return (1 << aw) - 1;
  endfunction
endpackage

// File: rtl/token_decoder_if.sv
// token_decoder_if: request, vocab sram read port and output stream of the detokenizer.
interface token_decoder_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4
);
  logic                  start;
  logic [ID_WIDTH-1:0]   token_id;
  logic                  busy;
  logic                  mem_cs;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  done;
  logic                  found;
  modport master(
    input  start, token_id, mem_rdata, out_ready,
    output busy, mem_cs, mem_addr, out_valid, out_data, out_last, done, found
  );
  modport slave(
    output start, token_id, mem_rdata, out_ready,
    input  busy, mem_cs, mem_addr, out_valid, out_data, out_last, done, found
  );
endinterface

// File: rtl/token_decoder_vocab_reader.sv
// vocab_reader: two-phase sram read, REQ drives the strobe, CHK presents the returned byte.
module vocab_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  mem_cs,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] rd_byte,
  output logic                  byte_valid
);
  logic chk;
  always_ff @(posedge clk) begin
    if (rst) chk <= 1'b0;
    else chk <= go && !chk;
  end
  assign mem_cs     = go && !chk;
  assign mem_addr   = mem_cs ? addr : '0;
  assign byte_valid = go && chk;
  assign rd_byte    = mem_rdata;
endmodule

// File: rtl/token_decoder.sv
// token_decoder: finds the token_id-th null-terminated word in the vocab sram and streams its bytes.
module token_decoder
  import tokenizer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4
) (
  input logic           clk,
  input logic           rst,
  token_decoder_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] END = ADDR_WIDTH'(end_addr(ADDR_WIDTH));
  localparam logic [ID_WIDTH:0] CNT_MAX = '1;
  state_t state, state_n;
  logic [ID_WIDTH-1:0] id, id_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [ID_WIDTH:0] cnt, cnt_n, cnt_inc;
  logic found, found_n, last, last_n;
  logic [DATA_WIDTH-1:0] data, data_n, rd_byte;
  logic rd_go, byte_valid, is_null, hit;
  assign rd_go = state == SKIP || state == EMIT;
  vocab_reader #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_reader (
    .clk(clk), .rst(rst), .go(rd_go), .addr(addr),
    .mem_cs(bus.mem_cs), .mem_addr(bus.mem_addr), .mem_rdata(bus.mem_rdata),
    .rd_byte(rd_byte), .byte_valid(byte_valid)
  );
  assign is_null = rd_byte == DATA_WIDTH'(NULL_CHAR);
  assign cnt_inc = (is_null && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
  assign hit     = is_null && cnt_inc == {1'b0, id};
  always_comb begin
    state_n = state;
    id_n    = id;
    addr_n  = addr;
    cnt_n   = cnt;
    found_n = found;
    data_n  = data;
    last_n  = last;
    case (state)
      IDLE: if (bus.start) begin
        id_n    = bus.token_id;
        addr_n  = '0;
        cnt_n   = '0;
        found_n = 1'b0;
        state_n = bus.token_id == '0 ? EMIT : SKIP;
      end
      SKIP: if (byte_valid) begin
        cnt_n = cnt_inc;
        if (addr == END) state_n = DONE;
        else begin
          addr_n  = addr + 1'b1;
          state_n = hit ? EMIT : SKIP;
        end
      end
      EMIT: if (byte_valid) begin
        data_n  = rd_byte;
        last_n  = is_null || addr == END;
        state_n = OUT;
      end
      OUT: if (bus.out_ready) begin
        found_n = last;
        addr_n  = last ? addr : addr + 1'b1;
        state_n = last ? DONE : EMIT;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id    <= '0;
      addr  <= '0;
      cnt   <= '0;
      found <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      id    <= id_n;
      addr  <= addr_n;
      cnt   <= cnt_n;
      found <= found_n;
      data  <= data_n;
      last  <= last_n;
    end
  end
  assign bus.busy      = state != IDLE;
  assign bus.out_valid = state == OUT;
  assign bus.out_data  = data;
  assign bus.out_last  = state == OUT && last;
  assign bus.done      = state == DONE;
  assign bus.found     = found;
endmodule

// File: tb/tb_token_decoder.sv
// tb_token_decoder: scoreboard bench driving the detokenizer against a small vocab sram model.
module tb_token_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  token_decoder_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ID_WIDTH(4)) bus();
  token_decoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ID_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] vocab [16];
  always @(posedge clk) if (bus.mem_cs) bus.mem_rdata <= vocab[bus.mem_addr];
  typedef struct packed {logic [7:0] data; logic last;} beat_t;
  beat_t exp_q[$];
  logic exp_found;
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input int id);
    int n, s;
    exp_q.delete();
    s = -1;
    n = 0;
    if (id == 0) s = 0;
    else for (int a = 0; a < 16; a++) begin
      if (vocab[a] == 8'h00) n++;
      if (vocab[a] == 8'h00 && n == id) begin
        s = a < 15 ? a + 1 : -1;
        break;
      end
    end
    exp_found = s >= 0;
    if (s >= 0) for (int a = s; a < 16; a++) begin
      exp_q.push_back({vocab[a], vocab[a] == 8'h00 || a == 15});
      if (vocab[a] == 8'h00) break;
    end
  endtask
  task automatic decode(input int id, input bit toggle, input bit intrude, input bit chk_lat);
    bit stall, fin;
    logic [7:0] hd;
    logic hl;
    int first;
    beat_t b;
    model(id);
    @(negedge clk);
    bus.token_id = id[3:0];
    bus.start = 1'b1;
    @(negedge clk);
    stall = 0;
    fin = 0;
    first = -1;
    hd = '0;
    hl = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      bus.start = intrude && k == 1;
      bus.token_id = (intrude && k == 1) ? 4'd2 : id[3:0];
      bus.out_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (stall) begin
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_data", 32'(bus.out_data), 32'(hd));
        check("stall_last", 32'(bus.out_last), 32'(hl));
      end
      if (bus.out_valid && first < 0) first = k;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          b = exp_q.pop_front();
          check("beat_data", 32'(bus.out_data), 32'(b.data));
          check("beat_last", 32'(bus.out_last), 32'(b.last));
        end
      end
      stall = bus.out_valid && !bus.out_ready;
      hd = bus.out_data;
      hl = bus.out_last;
      if (bus.done) begin
        fin = 1;
        check("done_found", 32'(bus.found), 32'(exp_found));
        check("beats_left", 32'(exp_q.size()), 0);
        if (chk_lat) check("first_beat_latency", 32'(first), 2);
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) check("done_timeout", 0, 1);
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_done", 32'(bus.done), 0);
    check("found_held", 32'(bus.found), 32'(exp_found));
  endtask
  function automatic logic [31:0] outs();
    return 32'({bus.busy, bus.mem_cs, bus.mem_addr, bus.out_valid, bus.out_data, bus.out_last, bus.done, bus.found});
  endfunction
  initial begin
    logic [7:0] img [16];
    img = '{8'h63, 8'h61, 8'h74, 8'h00, 8'h64, 8'h6F, 8'h67, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) vocab[i] = img[i];
    bus.start = 1'b0;
    bus.token_id = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    decode(0, 0, 0, 1);
    decode(1, 1, 0, 0);
    decode(2, 0, 0, 0);
    decode(9, 1, 0, 0);
    decode(10, 0, 0, 0);
    @(negedge clk);
    bus.token_id = 4'd0;
    bus.start = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
    check("reach_out_stalled", 32'(bus.out_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midop_reset_outputs", outs(), 0);
    rst = 1'b0;
    decode(0, 0, 0, 1);
    decode(1, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
